// File: rtl/microwave_timer.sv
// Microwave countdown timer: shifts BCD keypad digits into an MM:SS register,
// then counts it down to 00:00 at one decrement per TICKS_PER_SEC clocks.
module microwave_timer #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int CNT_W         = 10
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [3:0] data,
    input  logic       loadn,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LP_TOP = CNT_W'(TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [3:0]       r_mt, r_mo, r_st, r_so;
    logic [3:0]       w_nxt_mt, w_nxt_mo, w_nxt_st, w_nxt_so;
    logic [3:0]       w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic [CNT_W-1:0] r_presc;
    logic [CNT_W-1:0] w_nxt_presc;
    logic             r_running;
    logic             r_done;
    logic             w_key_ok;
    logic             w_nonzero;
    logic             w_dec_zero;

    assign w_key_ok  = !loadn && (data <= 4'd9);
    assign w_nonzero = |{r_mt, r_mo, r_st, r_so};

    // One-second BCD decrement with borrow chain (seconds tens wrap to 5).
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        w_dec_mt = r_mt;
        w_dec_mo = r_mo;
        w_dec_st = r_st;
        w_dec_so = r_so;
        if (r_so != 4'd0) begin
            w_dec_so = r_so - 4'd1;
        end else begin
            w_dec_so = 4'd9;
            if (r_st != 4'd0) begin
                w_dec_st = r_st - 4'd1;
            end else begin
                w_dec_st = 4'd5;
                if (r_mo != 4'd0) begin
                    w_dec_mo = r_mo - 4'd1;
                end else begin
                    w_dec_mo = 4'd9;
                    w_dec_mt = r_mt - 4'd1;
                end
            end
        end
    end

    assign w_dec_zero = ({w_dec_mt, w_dec_mo, w_dec_st, w_dec_so} == 16'h0000);

    // Next state, digits and prescaler; priority clear > stop > start > loadn.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_mt    = r_mt;
        w_nxt_mo    = r_mo;
        w_nxt_st    = r_st;
        w_nxt_so    = r_so;
        w_nxt_presc = r_presc;
        if (clear) begin
            w_nxt_state = S_IDLE;
            w_nxt_mt    = 4'd0;
            w_nxt_mo    = 4'd0;
            w_nxt_st    = 4'd0;
            w_nxt_so    = 4'd0;
            w_nxt_presc = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (stop) begin
                        w_nxt_state = S_IDLE;
                    end else if (start) begin
                        if (w_nonzero) begin
                            w_nxt_presc = '0;
                            w_nxt_state = S_RUN;
                        end
                    end else if (w_key_ok) begin
                        w_nxt_mt = r_mo;
                        w_nxt_mo = r_st;
                        w_nxt_st = r_so;
                        w_nxt_so = data;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        w_nxt_state = S_PAUSE;
                    end else if (r_presc == LP_TOP) begin
                        w_nxt_presc = '0;
                        w_nxt_mt    = w_dec_mt;
                        w_nxt_mo    = w_dec_mo;
                        w_nxt_st    = w_dec_st;
                        w_nxt_so    = w_dec_so;
                        if (w_dec_zero) begin
                            w_nxt_state = S_DONE;
                        end
                    end else begin
                        w_nxt_presc = r_presc + LP_ONE;
                    end
                end
                S_PAUSE: begin
                    if (!stop && start) begin
                        w_nxt_state = S_RUN;
                    end
                end
                S_DONE: begin
                    // A new digit lands in the already-zeroed register.
                    if (!stop && !start && w_key_ok) begin
                        w_nxt_mt    = 4'd0;
                        w_nxt_mo    = 4'd0;
                        w_nxt_st    = 4'd0;
                        w_nxt_so    = data;
                        w_nxt_state = S_IDLE;
                    end
                end
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    // State, digit, prescaler and status registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_mt      <= 4'd0;
            r_mo      <= 4'd0;
            r_st      <= 4'd0;
            r_so      <= 4'd0;
            r_presc   <= '0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_mt      <= w_nxt_mt;
            r_mo      <= w_nxt_mo;
            r_st      <= w_nxt_st;
            r_so      <= w_nxt_so;
            r_presc   <= w_nxt_presc;
            r_running <= (w_nxt_state == S_RUN);
            r_done    <= (w_nxt_state == S_DONE);
        end
    end

    assign min_tens = r_mt;
    assign min_ones = r_mo;
    assign sec_tens = r_st;
    assign sec_ones = r_so;
    assign running  = r_running;
    assign done     = r_done;

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with a small expected-value queue:
// each step pushes its expectation, clocks the DUT once, then pops and compares.
module tb_microwave_timer;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic [3:0] data = 4'd0;
    logic       loadn = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, done;

    typedef struct {
        string       tag;
        logic [17:0] val;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    microwave_timer #(.TICKS_PER_SEC(4), .CNT_W(3)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .data     (data),
        .loadn    (loadn),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, let one rising edge pass, sample at the falling edge.
    task automatic cyc(input logic rn, input logic ld, input logic [3:0] d,
                       input logic st, input logic sp, input logic cl);
        resetn = rn; loadn = ld; data = d; start = st; stop = sp; clear = cl;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1; loadn = 1'b1; data = 4'd0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Pop the oldest expectation and compare it with {digits, running, done}.
    task automatic check_out();
        exp_t        e;
        logic [17:0] obs;
        obs = {min_tens, min_ones, sec_tens, sec_ones, running, done};
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty: got %h want <entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: got digits=%h run=%b done=%b want digits=%h run=%b done=%b",
                       e.tag, obs[17:2], obs[1], obs[0], e.val[17:2], e.val[1], e.val[0]);
            end
        end
    endtask

    // One directed step: push expectation, apply inputs for one edge, check.
    task automatic go(input string tag, input logic rn, input logic ld, input logic [3:0] d,
                      input logic st, input logic sp, input logic cl,
                      input logic [15:0] dig, input logic run, input logic dn);
        exp_t e;
        e.tag = tag;
        e.val = {dig, run, dn};
        sb.push_back(e);
        cyc(rn, ld, d, st, sp, cl);
        check_out();
    endtask

    task automatic key(input string tag, input logic [3:0] d, input logic [15:0] dig,
                       input logic run, input logic dn);
        go(tag, 1'b1, 1'b0, d, 1'b0, 1'b0, 1'b0, dig, run, dn);
    endtask

    task automatic wait_chk(input string tag, input logic [15:0] dig, input logic run, input logic dn);
        go(tag, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, dig, run, dn);
    endtask

    initial begin
        // Reset held for three cycles with key strobes present.
        for (int i = 0; i < 3; i++)
            go("reset", 1'b0, 1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);

        // Digit entry, invalid digit, overflow of the oldest digit.
        key("entry_1", 4'd1, 16'h0001, 1'b0, 1'b0);
        key("entry_3", 4'd3, 16'h0013, 1'b0, 1'b0);
        key("entry_0", 4'd0, 16'h0130, 1'b0, 1'b0);
        key("entry_bad12", 4'd12, 16'h0130, 1'b0, 1'b0);
        key("entry_5", 4'd5, 16'h1305, 1'b0, 1'b0);
        key("entry_6", 4'd6, 16'h3056, 1'b0, 1'b0);
        key("entry_7", 4'd7, 16'h0567, 1'b0, 1'b0);
        key("entry_8", 4'd8, 16'h5678, 1'b0, 1'b0);
        key("entry_9", 4'd9, 16'h6789, 1'b0, 1'b0);
        go("clear_idle", 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);

        // Countdown 01:00 with borrow through every digit.
        key("cd_1", 4'd1, 16'h0001, 1'b0, 1'b0);
        key("cd_0a", 4'd0, 16'h0010, 1'b0, 1'b0);
        key("cd_0b", 4'd0, 16'h0100, 1'b0, 1'b0);
        go("cd_start", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0100, 1'b1, 1'b0);
        idle(2);
        wait_chk("cd_before_1s", 16'h0100, 1'b1, 1'b0);
        wait_chk("cd_borrow_0059", 16'h0059, 1'b1, 1'b0);
        idle(115);
        wait_chk("cd_30s", 16'h0030, 1'b1, 1'b0);
        idle(118);
        wait_chk("cd_0001", 16'h0001, 1'b1, 1'b0);
        wait_chk("cd_done", 16'h0000, 1'b0, 1'b1);
        go("done_start_ign", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        wait_chk("done_hold", 16'h0000, 1'b0, 1'b1);
        key("done_key7", 4'd7, 16'h0007, 1'b0, 1'b0);

        // Pause and resume: prescaler must hold its value while paused.
        go("pr_clear", 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        key("pr_1", 4'd1, 16'h0001, 1'b0, 1'b0);
        key("pr_0", 4'd0, 16'h0010, 1'b0, 1'b0);
        go("pr_start", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0);
        idle(3);
        wait_chk("pr_0009", 16'h0009, 1'b1, 1'b0);
        idle(2);
        go("pr_stop", 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0);
        idle(19);
        wait_chk("pr_hold20", 16'h0009, 1'b0, 1'b0);
        go("pr_stop_again", 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 16'h0009, 1'b0, 1'b0);
        go("pr_resume", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0009, 1'b1, 1'b0);
        wait_chk("pr_resume_1", 16'h0009, 1'b1, 1'b0);
        wait_chk("pr_resume_2", 16'h0008, 1'b1, 1'b0);

        // Priority and ignore cases.
        go("pri_clear", 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        go("pri_start_zero", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        key("pri_key2", 4'd2, 16'h0002, 1'b0, 1'b0);
        go("pri_start", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0);
        go("pri_start_stop", 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b0, 1'b0);
        key("pri_key_pause", 4'd5, 16'h0002, 1'b0, 1'b0);
        go("pri_restart", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0);
        key("pri_key_run", 4'd9, 16'h0002, 1'b1, 1'b0);
        go("pri_clear_start", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        wait_chk("pri_idle_after", 16'h0000, 1'b0, 1'b0);

        // Reset in the middle of a run.
        key("rst_key4", 4'd4, 16'h0004, 1'b0, 1'b0);
        go("rst_start", 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 16'h0004, 1'b1, 1'b0);
        idle(2);
        go("rst_midrun", 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        idle(4);
        wait_chk("rst_stays_idle", 16'h0000, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/microwave_timer.md
Name: microwave_timer

Overview:
- Countdown stage directly downstream of the keypad encoder.
- Consumes the encoder's BCD digit and its active-low load strobe, shifting digits into a 4-digit MM:SS register in the usual microwave-keypad style.
- On start, counts the register down to 00:00 at one decrement per second.
- Drives the digit display and the cook-done flag consumed by the control/magnetron logic.

Parameters:
TICKS_PER_SEC, 1000, clk cycles per one-second decrement (1 kHz system clock); legal range >= 2
CNT_W, 10, prescaler counter width; must satisfy 2^CNT_W >= TICKS_PER_SEC

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
data  input  4  BCD digit from encoder
loadn  input  1  active-low digit strobe from encoder; each low cycle is one key event
start  input  1  active-high start/resume pulse
stop  input  1  active-high pause pulse
clear  input  1  active-high clear pulse
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
running  output  1  high while in RUN
done  output  1  high while in DONE

Behaviour:
- One clock (clk); reset is synchronous and active-low (resetn). Every register updates on the rising edge of clk.
- Reset, or any cycle with resetn=0:
  - all digits 0; running=0; done=0; prescaler 0; state IDLE.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Priority in every state: resetn > clear > stop > start > loadn.
- clear, any state: digits 0, prescaler 0, next state IDLE.
- Digit entry:
  - Accepted only in IDLE and DONE, when loadn=0 and data<=9.
  - Shift: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=data.
  - Result is visible on the cycle after the strobe is sampled.
  - In DONE, the shifted-in digit goes into the zeroed register and the state moves to IDLE.
  - A loadn held low for N cycles shifts N times; the encoder guarantees single-cycle strobes.
  - data>9, or loadn in RUN/PAUSE: ignored, no state change.
- IDLE + start:
  - If any digit is non-zero: prescaler<=0, go to RUN.
  - If all digits are zero: ignored, stay in IDLE.
- RUN:
  - Prescaler increments each cycle.
  - When prescaler==TICKS_PER_SEC-1: prescaler<=0 and the register decrements by one second.
  - The first decrement lands TICKS_PER_SEC cycles after the start cycle.
- Decrement, as BCD borrow chain:
  - sec_ones>0: sec_ones-1. Otherwise sec_ones<=9 and borrow into sec_tens.
  - sec_tens>0: sec_tens-1. Otherwise sec_tens<=5 and borrow into min_ones.
  - min_ones>0: min_ones-1. Otherwise min_ones<=9 and min_tens-1.
  - Entered sec_tens values 6–9 are legal (e.g. 0:90 = 90 s) and count down normally.
- Decrement reaching 00:00: go to DONE on the same edge. done=1, running=0 from the next cycle.
- RUN + stop: go to PAUSE. Digits and prescaler are held.
- PAUSE + start: back to RUN, prescaler resumes from its held value.
- PAUSE + stop: no effect.
- start and stop in the same cycle: stop wins (RUN→PAUSE; IDLE/PAUSE unchanged).
- DONE:
  - Digits stay 0 and done stays 1 until clear, a valid digit, or reset.
  - start in DONE is ignored.
- Reset mid-RUN: immediate return to IDLE with zero digits on the next edge.

Test Plan:
- Reset state: TICKS_PER_SEC=4; hold resetn=0 for 3 cycles with loadn pulses → all digits 0, running=0, done=0 throughout.
- Entry:
  - Single-cycle loadn strobes with data 1,3,0 → digits 0,1,3,0 (01:30).
  - Then data=12 strobe → unchanged.
  - Then 5 more strobes → the oldest digit is shifted out.
- Countdown with borrow:
  - Enter 1,0,0 (01:00), start.
  - After 4 cycles → 00:59. Confirm running=1.
  - 60 s after start → 00:00 with done=1, running=0 on the next cycle.
- Pause/resume:
  - Enter 0:10, start; stop after 6 cycles.
  - Digits hold at 00:09 for 20 cycles; the prescaler does not advance.
  - start → next decrement to 00:08 occurs 2 cycles later.
- Priority and ignore cases:
  - start with 00:00 → stays IDLE.
  - start+stop same cycle while RUN → PAUSE.
  - clear+start same cycle → IDLE, digits 0.
  - loadn during RUN → digits unaffected.
- DONE exit and mid-run reset:
  - In DONE, strobe data=7 → 00:07, done=0, IDLE.
  - resetn=0 mid-RUN → IDLE, digits 0 next cycle.
